ub_read_streamer: RTL and testbench
===================================

UB_READ_STREAMER -- requirements
Module: ub_read_streamer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 128, one buffer row (16 x 8b); ADDR_WIDTH, default 8, buffer address width (256 rows).
REQ-002 Ports SHALL be:
clk  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that launches a transfer
base_addr  in  ADDR_WIDTH  first row to read
row_count  in  ADDR_WIDTH+1  rows to read, 0..256
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer completion
enb  out  1  buffer read enable
addrb  out  ADDR_WIDTH  buffer read address
doutb  in  DATA_WIDTH  buffer read data, valid the cycle after enb
m_valid  out  1  output row valid
m_ready  in  1  consumer accepts row
m_data  out  DATA_WIDTH  output row
m_last  out  1  marks final row of transfer
REQ-003 One clock SHALL be used; reset SHALL be asynchronous and active-low.

Function
REQ-004 FSM SHALL have states IDLE, RUN and DRAIN.
REQ-005 IDLE: start captures base_addr and row_count; row_count>0 -> RUN; row_count=0 -> done pulse next cycle, stay IDLE, no reads issued.
REQ-006 start while busy=1 SHALL be ignored; captured parameters SHALL stay unchanged.
REQ-007 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-008 RUN: enb=1 only when rows_issued<row_count and (fifo_count + inflight) <= 2; addrb = base_addr + rows_issued, mod 2^ADDR_WIDTH (wraps 255 -> 0).
REQ-009 Buffer read latency SHALL be exactly 1 cycle: data for enb in cycle N is written into a 4-entry output FIFO at the end of cycle N+1.
REQ-010 RUN -> DRAIN when the last read is issued; DRAIN -> IDLE on the handshake of the m_last row.
REQ-011 Output handshake: a row transfers on m_valid & m_ready; m_valid = FIFO not empty; m_data = FIFO head.
REQ-012 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-013 m_last=1 exactly on the row numbered row_count-1 of the transfer.
REQ-014 FIFO SHALL never overflow and no row SHALL be dropped or duplicated under any m_ready pattern.
REQ-015 With m_ready held 1, throughput SHALL be 1 row/cycle.
REQ-016 With m_ready held 1, the first m_valid SHALL occur 3 cycles after the start cycle.
REQ-017 Rows SHALL emerge in address order.
REQ-018 done SHALL pulse for 1 cycle in the cycle after the m_last handshake, together with busy falling.
REQ-019 A start in that same cycle SHALL be accepted, since the FSM is already IDLE.
REQ-020 enb SHALL be 0 whenever no read is issued, including every cycle in IDLE and DRAIN.

Reset
REQ-021 reset_n=0 SHALL immediately force: state IDLE, busy=0, done=0, enb=0, addrb=0, m_valid=0, m_last=0, m_data=0, FIFO empty, all counters 0.
REQ-022 Reset mid-transfer SHALL abort it: no done pulse, and in-flight buffer data is discarded.
REQ-023 The first start after reset release SHALL behave normally.

Verification
REQ-024 Buffer pre-loaded with row i = {16 bytes of i}; base=0, count=4, m_ready=1 -> enb in cycles 1-4 with addrb 0..3; m_valid in cycles 3-6 with rows 0..3; m_last on row 3; done in cycle 7.
REQ-025 Wrap test: base=254, count=4 -> addrb 254, 255, 0, 1; data order matches.
REQ-026 Backpressure: count=16, m_ready toggled 1-0-0-1 pseudo-randomly -> all 16 rows delivered once, in order, stable while stalled; enb never issued with fifo_count+inflight>2.
REQ-027 count=0 -> done the next cycle; enb and m_valid never asserted. count=256 -> 256 rows delivered, m_last on the 256th.
REQ-028 reset_n pulsed low mid-transfer (after 5 of 10 rows) -> outputs go to reset values at once; no done; a new start with count=2 delivers exactly 2 rows.
REQ-029 start pulsed while busy -> ignored; start in the done cycle -> new transfer begins.

Source files
------------

// File: rtl/ub_read_streamer_if.sv
// Control, buffer-read and output-stream signals of the unified-buffer read streamer.
// The streamer itself takes the master modport; its environment takes the slave side.
interface ub_read_streamer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   row_count;
  logic                  busy;
  logic                  done;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  start, base_addr, row_count, doutb, m_ready,
    output busy, done, enb, addrb, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, row_count, doutb, m_ready,
    input  busy, done, enb, addrb, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ub_read_streamer.sv
// Streams row_count consecutive buffer rows from base_addr into a 4-entry FIFO
// feeding a valid/ready output, with credit-limited reads so the FIFO never overflows.
module ub_read_streamer #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  ub_read_streamer_if.master  bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_issued;
  logic [CW-1:0]         r_rows_out;
  logic                  r_inflight;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_mem [4];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_fifo_count;
  logic                  w_enb;
  logic                  w_done_set;
  logic                  w_capture;
  logic                  w_room;
  logic                  w_valid;
  logic                  w_last;
  logic                  w_pop;

  // Rows already in the FIFO plus the one whose data arrives next cycle must leave a free slot.
  assign w_room  = ({1'b0, r_fifo_count} + {3'b000, r_inflight}) <= 4'd2;
  assign w_valid = (r_fifo_count != 3'd0);
  assign w_last  = w_valid && (r_rows_out == (r_count - C_ONE));
  assign w_pop   = w_valid && bus.m_ready;

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.enb     = w_enb;
  assign bus.addrb   = r_base + r_issued[ADDR_WIDTH-1:0];
  assign bus.m_valid = w_valid;
  assign bus.m_data  = r_mem[r_rd_ptr];
  assign bus.m_last  = w_last;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, read issue and completion decode.
  always_comb begin
    w_next     = r_state;
    w_enb      = 1'b0;
    w_done_set = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_capture = 1'b1;
          if (bus.row_count == C_ZERO) begin
            w_done_set = 1'b1;
            w_next     = S_IDLE;
          end else begin
            w_next = S_RUN;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if ((r_issued < r_count) && w_room) begin
          w_enb = 1'b1;
          if (r_issued == (r_count - C_ONE)) begin
            w_next = S_DRAIN;
          end else begin
            w_next = S_RUN;
          end
        end else begin
          w_next = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_last) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end else begin
          w_next = S_DRAIN;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Transfer parameters, progress counters, read-latency tracker and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base     <= {ADDR_WIDTH{1'b0}};
      r_count    <= C_ZERO;
      r_issued   <= C_ZERO;
      r_rows_out <= C_ZERO;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_base     <= bus.base_addr;
        r_count    <= bus.row_count;
        r_issued   <= C_ZERO;
        r_rows_out <= C_ZERO;
      end else begin
        if (w_enb) begin
          r_issued <= r_issued + C_ONE;
        end
        if (w_pop) begin
          r_rows_out <= r_rows_out + C_ONE;
        end
      end
      r_inflight <= w_enb;
      r_done     <= w_done_set;
    end
  end

  // Output FIFO: buffer data lands one cycle after its read was issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_fifo_count <= 3'd0;
    end else begin
      if (r_inflight) begin
        r_mem[r_wr_ptr] <= bus.doutb;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({r_inflight, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 3'd1;
        2'b01:   r_fifo_count <= r_fifo_count - 3'd1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_ub_read_streamer.sv
// Directed bench for ub_read_streamer: buffer model holding row i = {16{i}},
// a negedge monitor collecting reads and delivered rows, and hand-computed expectations.
module tb_ub_read_streamer;
  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  int   rdy_mode;
  int   n_iss;
  int   n_pop;
  int   n_done;
  logic stall;
  logic [127:0] s_data;
  logic s_last;
  logic [127:0] mem [256];
  logic [7:0]   q_addr [$];
  logic [127:0] q_data [$];
  logic         q_last [$];

  ub_read_streamer_if #(.DATA_WIDTH(128), .ADDR_WIDTH(8)) bus ();

  ub_read_streamer #(.DATA_WIDTH(128), .ADDR_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] row_of(input logic [7:0] a);
    return {16{a}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle read latency buffer model.
  always @(posedge clk) begin
    if (bus.enb) bus.doutb <= mem[bus.addrb];
  end

  // Monitor: records reads and handshakes, checks credit limit and stall stability.
  always @(negedge clk) begin
    if (!reset_n) begin
      n_iss = 0;
      n_pop = 0;
      stall = 1'b0;
    end else begin
      if (bus.enb) begin
        chk("credit_limit", ((n_iss - n_pop) <= 2), 1'b1);
        q_addr.push_back(bus.addrb);
        n_iss++;
      end
      if (stall) begin
        chk("stall_valid", bus.m_valid, 1'b1);
        chk("stall_data", bus.m_data, s_data);
        chk("stall_last", bus.m_last, s_last);
      end
      if (bus.m_valid && bus.m_ready) begin
        q_data.push_back(bus.m_data);
        q_last.push_back(bus.m_last);
        n_pop++;
      end
      stall  = bus.m_valid && !bus.m_ready;
      s_data = bus.m_data;
      s_last = bus.m_last;
      if (bus.done) n_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rdy_mode != 0) bus.m_ready = 1'($urandom_range(0, 1));
    else bus.m_ready = 1'b1;
  endtask

  task automatic start_xfer(input logic [7:0] base, input logic [8:0] count);
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.row_count = count;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, bus.done, 1'b1);
  endtask

  task automatic verify(input logic [7:0] base, input int count, input string tag);
    logic [7:0] a;
    chk({tag, "_n_reads"}, q_addr.size(), count);
    chk({tag, "_n_rows"}, q_data.size(), count);
    for (int i = 0; i < count && i < q_data.size() && i < q_addr.size(); i++) begin
      a = base + 8'(i);
      chk({tag, "_addr"}, q_addr[i], a);
      chk({tag, "_data"}, q_data[i], row_of(a));
      chk({tag, "_last"}, q_last[i], (i == count - 1));
    end
  endtask

  initial begin
    int ndone0;
    int nq;
    tests = 0;
    fails = 0;
    rdy_mode = 0;
    n_done = 0;
    for (int i = 0; i < 256; i++) mem[i] = row_of(8'(i));
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = 8'd0;
    bus.row_count = 9'd0;
    bus.m_ready   = 1'b1;
    bus.doutb     = 128'd0;
    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_enb", bus.enb, 1'b0);
    chk("rst_addrb", bus.addrb, 8'd0);
    chk("rst_valid", bus.m_valid, 1'b0);
    chk("rst_last", bus.m_last, 1'b0);
    chk("rst_data", bus.m_data, 128'd0);
    step();
    reset_n = 1'b1;
    step();

    // Cycle-exact basic transfer: base 0, 4 rows.
    start_xfer(8'd0, 9'd4);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("basic_enb_c%0d", c), bus.enb, (c <= 4));
      if (c <= 4) chk($sformatf("basic_addrb_c%0d", c), bus.addrb, 8'(c - 1));
      chk($sformatf("basic_valid_c%0d", c), bus.m_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk($sformatf("basic_data_c%0d", c), bus.m_data, row_of(8'(c - 3)));
      chk($sformatf("basic_last_c%0d", c), bus.m_last, (c == 6));
      chk($sformatf("basic_done_c%0d", c), bus.done, (c == 7));
      chk($sformatf("basic_busy_c%0d", c), bus.busy, (c <= 6));
      if (c < 7) step();
    end
    step();
    chk("basic_done_one_cycle", bus.done, 1'b0);
    verify(8'd0, 4, "basic");

    // Address wrap.
    start_xfer(8'd254, 9'd4);
    wait_done(100, "wrap");
    verify(8'd254, 4, "wrap");

    // Backpressure with pseudo-random ready.
    rdy_mode = 1;
    start_xfer(8'd40, 9'd16);
    wait_done(600, "bp");
    verify(8'd40, 16, "bp");
    rdy_mode = 0;
    step();

    // Zero-length transfer.
    start_xfer(8'd5, 9'd0);
    chk("zero_done", bus.done, 1'b1);
    chk("zero_busy", bus.busy, 1'b0);
    step();
    chk("zero_done_drop", bus.done, 1'b0);
    step();
    chk("zero_reads", q_addr.size(), 0);
    chk("zero_rows", q_data.size(), 0);

    // Full 256-row transfer.
    start_xfer(8'd0, 9'd256);
    wait_done(2000, "full");
    verify(8'd0, 256, "full");
    step();

    // Start while busy is ignored; start in the done cycle is taken.
    start_xfer(8'd10, 9'd6);
    step();
    bus.start     = 1'b1;
    bus.base_addr = 8'd100;
    bus.row_count = 9'd3;
    step();
    bus.start = 1'b0;
    wait_done(200, "ignore");
    verify(8'd10, 6, "ignore");
    start_xfer(8'd50, 9'd2);
    chk("done_cycle_start_busy", bus.busy, 1'b1);
    wait_done(100, "chain");
    verify(8'd50, 2, "chain");
    step();

    // Reset mid-transfer after 5 of 10 rows.
    start_xfer(8'd0, 9'd10);
    for (int k = 0; k < 50 && q_data.size() < 5; k++) step();
    chk("mid_rows_before_reset", q_data.size(), 5);
    ndone0 = n_done;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_enb", bus.enb, 1'b0);
    chk("mid_rst_addrb", bus.addrb, 8'd0);
    chk("mid_rst_valid", bus.m_valid, 1'b0);
    chk("mid_rst_last", bus.m_last, 1'b0);
    chk("mid_rst_data", bus.m_data, 128'd0);
    nq = q_data.size();
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("mid_no_done", n_done, ndone0);
    chk("mid_no_more_rows", q_data.size(), nq);
    start_xfer(8'd20, 9'd2);
    wait_done(100, "post_rst");
    verify(8'd20, 2, "post_rst");
    step();
    step();
    chk("post_rst_rows_exact", q_data.size(), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
